// File: rtl/scroll_scheduler.sv
// Game-flow controller: gates frame ticks through an IDLE/RUN/PAUSED/OVER FSM into
// registered one-cycle scroll and lane move strobes, and counts scrolled rows.
module scroll_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int TICK_FRAMES = 2,
    parameter int MOVE_AMT    = 2,
    parameter int ROW_PX      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 collide,
    input  logic [1:0]           level,
    output logic                 scroll_move,
    output logic [NUM_LANES-1:0] lane_move,
    output logic                 follower_reset,
    output logic [7:0]           row_count,
    output logic [1:0]           state
);

    localparam int FCW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam int LCW = 3;
    localparam int PXW = (ROW_PX > 1) ? $clog2(ROW_PX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t         cur;
    state_t         nxt;
    logic [FCW-1:0] frame_cnt;
    logic [LCW-1:0] lane_cnt  [NUM_LANES];
    logic [LCW-1:0] lane_last [NUM_LANES];
    logic [PXW-1:0] pix_acc;
    logic [PXW:0]   pix_sum;
    logic [1:0]     lvl;
    logic           qual;
    logic           scroll_due;

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (collide) nxt = OVER;
                     else if (pause) nxt = PAUSED;
            PAUSED:  if (collide) nxt = OVER;
                     else if (!pause) nxt = RUN;
            OVER:    if (start) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // A tick only counts when play stays in RUN across this edge.
    assign qual       = frame_tick && (cur == RUN) && (nxt == RUN);
    assign scroll_due = qual && (frame_cnt == FCW'(TICK_FRAMES - 1));
    assign pix_sum    = {1'b0, pix_acc} + (PXW + 1)'(MOVE_AMT);
    assign state      = cur;

    // Last count value before a lane pulses: period - 1 = (i mod 4) + 3 - level.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_last[i] = LCW'(i % 4) + 3'd3 - {1'b0, lvl};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur            <= IDLE;
            follower_reset <= 1'b1;
            scroll_move    <= 1'b0;
            lane_move      <= '0;
            row_count      <= '0;
            frame_cnt      <= '0;
            pix_acc        <= '0;
            lvl            <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
        end else begin
            cur            <= nxt;
            follower_reset <= (nxt == IDLE);
            scroll_move    <= 1'b0;
            lane_move      <= '0;
            if (cur == IDLE && start) begin
                frame_cnt <= '0;
                pix_acc   <= '0;
                row_count <= '0;
                lvl       <= level;
                for (int unsigned i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
            end else if (qual) begin
                if (scroll_due) begin
                    scroll_move <= 1'b1;
                    frame_cnt   <= '0;
                    if (pix_sum >= (PXW + 1)'(ROW_PX)) begin
                        pix_acc <= '0;
                        if (row_count != 8'hFF) row_count <= row_count + 8'd1;
                    end else begin
                        pix_acc <= pix_sum[PXW-1:0];
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (lane_cnt[i] == lane_last[i]) begin
                        lane_move[i] <= 1'b1;
                        lane_cnt[i]  <= '0;
                    end else begin
                        lane_cnt[i]  <= lane_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scroll_scheduler.sv
// Directed self-checking bench for scroll_scheduler (4 lanes, 2 frames/step, 2 px, 32 px rows).
module tb_scroll_scheduler;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       collide;
    logic [1:0] level;
    logic       scroll_move;
    logic [3:0] lane_move;
    logic       follower_reset;
    logic [7:0] row_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic       sm;
    logic [3:0] lm;
    int         moves;

    logic [3:0] exp2 [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001,
                             4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp3 [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b1011,
                             4'b0001, 4'b0111, 4'b0001, 4'b1011};

    scroll_scheduler #(
        .NUM_LANES   (4),
        .TICK_FRAMES (2),
        .MOVE_AMT    (2),
        .ROW_PX      (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .pause          (pause),
        .collide        (collide),
        .level          (level),
        .scroll_move    (scroll_move),
        .lane_move      (lane_move),
        .follower_reset (follower_reset),
        .row_count      (row_count),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame_tick pulse; returns strobes as seen in the cycle after the tick.
    task automatic tick(output logic s, output logic [3:0] l);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        s = scroll_move;
        l = lane_move;
    endtask

    task automatic run_ticks(input int n, output int cnt);
        logic       s;
        logic [3:0] l;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick(s, l);
            if (s) cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
        collide = 1'b0; level = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_freset", follower_reset, 1);
        chk("rst_strobes", {scroll_move, lane_move}, 0);
        chk("rst_rows", row_count, 0);
        rst_n = 1'b1;

        // collide is ignored in IDLE
        @(negedge clk) collide = 1'b1;
        @(negedge clk) collide = 1'b0;
        chk("idle_collide", state, 0);
        chk("idle_freset", follower_reset, 1);

        // game 1 at level 0
        level = 2'd0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("g1_state", state, 1);
        chk("g1_freset", follower_reset, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(sm, lm);
            chk("t2_scroll", sm, (k % 2 == 0) ? 1 : 0);
            chk("t2_lanes", lm, exp2[k-1]);
            @(negedge clk);
            chk("t2_width", {scroll_move, lane_move}, 0);
        end
        chk("t2_rows", row_count, 0);

        // pause mid-count
        tick(sm, lm);
        chk("t5_pre_scroll", sm, 0);
        chk("t5_pre_lanes", lm, 0);
        pause = 1'b1;
        @(negedge clk);
        chk("t5_paused", state, 2);
        for (int k = 0; k < 3; k++) begin
            tick(sm, lm);
            chk("t5_frozen", {sm, lm}, 0);
            chk("t5_hold", state, 2);
        end
        pause = 1'b0;
        @(negedge clk);
        chk("t5_resume", state, 1);
        chk("t5_resume_quiet", {scroll_move, lane_move}, 0);
        tick(sm, lm);
        chk("t5_first_scroll", sm, 1);
        chk("t5_first_lanes", lm, 4'b0010);

        // rows: 5 moves so far, 10 more then the 16th completes a row
        run_ticks(21, moves);
        chk("t4_moves", moves, 10);
        chk("t4_rows_pre", row_count, 0);
        tick(sm, lm);
        chk("t4_scroll16", sm, 1);
        chk("t4_rows_one", row_count, 1);
        run_ticks(254 * 32, moves);
        chk("t4_rows_255", row_count, 255);
        run_ticks(32, moves);
        chk("t4_sat_moves", moves, 16);
        chk("t4_rows_sat", row_count, 255);

        // collide and pause together: collide wins
        collide = 1'b1; pause = 1'b1;
        @(negedge clk);
        chk("t6_over", state, 3);
        chk("t6_freset", follower_reset, 0);
        collide = 1'b0; pause = 1'b0;
        tick(sm, lm);
        chk("t6_no_strobes", {sm, lm}, 0);
        chk("t6_rows_held", row_count, 255);
        start = 1'b1;
        @(negedge clk);
        chk("t6_idle", state, 0);
        chk("t6_idle_freset", follower_reset, 1);
        chk("t6_idle_rows", row_count, 255);
        start = 1'b0;

        // game 2 at level 3, level changed mid-run
        level = 2'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("g2_state", state, 1);
        chk("g2_rows_clr", row_count, 0);
        chk("g2_freset", follower_reset, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) level = 2'd0;
            tick(sm, lm);
            chk("t3_scroll", sm, (k % 2 == 0) ? 1 : 0);
            chk("t3_lanes", lm, exp3[k-1]);
        end

        // async reset with strobes live
        tick(sm, lm);
        chk("t1_pending", lm, 4'b0101);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_state", state, 0);
        chk("t1_freset", follower_reset, 1);
        chk("t1_strobes", {scroll_move, lane_move}, 0);
        chk("t1_rows", row_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t1_after", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
